aes_key_expand: RTL and testbench

- Iterative AES-128 key schedule. Produces round keys 0..ROUNDS at one per clock.
- Sits directly upstream of the AddRoundKey stage and drives its 128-bit key input, one round key per round.
- Starts on a single start pulse and streams round keys with a valid flag and round index. No backpressure.

---
 rtl/aes_key_expand.sv | 145 ++++++++++++++
 tb/tb_aes_key_expand.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: streams round keys 0..ROUNDS, one per clock, after a start pulse.
// Optional round-key store bank enabled by defining KEY_EXP_STORE_EN.
module aes_key_expand #(
   parameter int unsigned ROUNDS = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [127:0] key_in,
   output logic         busy,
   output logic         rk_valid,
   output logic [3:0]   rk_idx,
   output logic [127:0] rk_out,
   output logic         done
`ifdef KEY_EXP_STORE_EN
   ,
   input  logic [3:0]   rd_idx,
   output logic [127:0] rd_key
`endif
);

   localparam logic [3:0] LAST = 4'(ROUNDS);

   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   typedef enum logic {IDLE, EXPAND} state_t;

   state_t        state, state_d;
   logic          busy_d, rk_valid_d, done_d;
   logic [3:0]    rk_idx_d;
   logic [127:0]  rk_out_d;
   logic [7:0]    rcon, rcon_d;

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // One step of the schedule: w3 is rotated left one byte, substituted and mixed with rcon.
   function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] t, w0, w1, w2, w3;
      t  = sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h0};
      w0 = k[127:96] ^ t;
      w1 = k[95:64]  ^ w0;
      w2 = k[63:32]  ^ w1;
      w3 = k[31:0]   ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   always_comb begin
      state_d    = state;
      busy_d     = busy;
      rk_valid_d = rk_valid;
      done_d     = done;
      rk_idx_d   = rk_idx;
      rk_out_d   = rk_out;
      rcon_d     = rcon;
      case (state)
         IDLE: begin
            if (start) begin
               rk_out_d   = key_in;
               rk_idx_d   = 4'd0;
               rk_valid_d = 1'b1;
               busy_d     = 1'b1;
               done_d     = 1'b0;
               rcon_d     = 8'h01;
               state_d    = EXPAND;
            end
         end
         EXPAND: begin
            if (rk_idx < LAST) begin
               rk_out_d = next_key(rk_out, rcon);
               rk_idx_d = rk_idx + 4'd1;
               rcon_d   = xtime(rcon);
               done_d   = (rk_idx + 4'd1 == LAST);
            end else begin
               rk_valid_d = 1'b0;
               busy_d     = 1'b0;
               done_d     = 1'b0;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         busy     <= 1'b0;
         rk_valid <= 1'b0;
         done     <= 1'b0;
         rk_idx   <= 4'd0;
         rk_out   <= '0;
         rcon     <= 8'h01;
      end else begin
         state    <= state_d;
         busy     <= busy_d;
         rk_valid <= rk_valid_d;
         done     <= done_d;
         rk_idx   <= rk_idx_d;
         rk_out   <= rk_out_d;
         rcon     <= rcon_d;
      end
   end

`ifdef KEY_EXP_STORE_EN
   // Round-key bank so the decrypt path can walk keys in reverse without re-expanding.
   logic [127:0] bank [0:10];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 11; i++) bank[i] <= '0;
      end else if (rk_valid && rk_idx <= 4'd10) begin
         bank[rk_idx] <= rk_out;
      end
   end

   always_comb begin
      rd_key = '0;
      if (rd_idx <= 4'd10) rd_key = bank[rd_idx];
   end
`endif

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand: FIPS-197 schedule, start held high, mid-run reset,
// a ROUNDS=2 instance, and the store bank when KEY_EXP_STORE_EN is defined.
module tb_aes_key_expand;

   typedef struct {
      logic [3:0]   idx;
      logic [127:0] key;
   } vec_t;

   typedef struct {
      logic [3:0]   idx;
      logic [127:0] key;
      logic         done;
      logic         chk;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n, start, start_b;
   logic [127:0] key_in, key_b;
   logic         busy, rk_valid, done, busy_b, rk_valid_b, done_b;
   logic [3:0]   rk_idx, rk_idx_b;
   logic [127:0] rk_out, rk_out_b;
`ifdef KEY_EXP_STORE_EN
   logic [3:0]   rd_idx, rd_idx_b;
   logic [127:0] rd_key, rd_key_b;
`endif

   int   total = 0;
   int   bad   = 0;
   vec_t fips [11];
   vec_t zk   [4];
   exp_t sb   [$];
   exp_t sb_b [$];

   always #5 clk = ~clk;

   aes_key_expand #(.ROUNDS(10)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in),
      .busy(busy), .rk_valid(rk_valid), .rk_idx(rk_idx), .rk_out(rk_out), .done(done)
`ifdef KEY_EXP_STORE_EN
      , .rd_idx(rd_idx), .rd_key(rd_key)
`endif
   );

   aes_key_expand #(.ROUNDS(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start_b), .key_in(key_b),
      .busy(busy_b), .rk_valid(rk_valid_b), .rk_idx(rk_idx_b), .rk_out(rk_out_b), .done(done_b)
`ifdef KEY_EXP_STORE_EN
      , .rd_idx(rd_idx_b), .rd_key(rd_key_b)
`endif
   );

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp_v);
      total++;
      if (act !== exp_v) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp_v);
      end
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Advance one clock and pop/compare every round key either instance presents.
   task automatic step();
      exp_t e;
      @(posedge clk);
      #1;
      if (rk_valid) begin
         if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL a_unexpected_valid: got idx %0d want no valid", rk_idx);
         end else begin
            e = sb.pop_front();
            chk("a_idx", 128'(rk_idx), 128'(e.idx));
            if (e.chk) chk("a_key", rk_out, e.key);
            chk("a_done", 128'(done), 128'(e.done));
            chk("a_busy", 128'(busy), 128'(1));
         end
      end else begin
         chk("a_done_idle", 128'(done), 128'(0));
      end
      if (rk_valid_b) begin
         if (sb_b.size() == 0) begin
            total++; bad++;
            $display("FAIL b_unexpected_valid: got idx %0d want no valid", rk_idx_b);
         end else begin
            e = sb_b.pop_front();
            chk("b_idx", 128'(rk_idx_b), 128'(e.idx));
            chk("b_key", rk_out_b, e.key);
            chk("b_done", 128'(done_b), 128'(e.done));
         end
      end
   endtask

   task automatic push_fips(input bit to_b, input int last, input int upto);
      exp_t e;
      for (int i = 0; i <= upto; i++) begin
         e.idx = fips[i].idx; e.key = fips[i].key; e.done = (i == last); e.chk = 1'b1;
         if (to_b) sb_b.push_back(e); else sb.push_back(e);
      end
   endtask

   task automatic push_zero();
      exp_t e;
      for (int i = 0; i <= 10; i++) begin
         e.idx = 4'(i); e.done = (i == 10); e.chk = (i < 4);
         e.key = (i < 4) ? zk[i].key : '0;
         sb.push_back(e);
      end
   endtask

   // Count consecutive valid samples (the current one included), bounded.
   task automatic run_valid(input bit which, output int n);
      n = 0;
      while ((which ? rk_valid_b : rk_valid) && n < 40) begin
         n++;
         step();
      end
   endtask

   initial begin
      int n;
      fips[0]  = '{4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
      fips[1]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
      fips[2]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
      fips[3]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
      fips[4]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
      fips[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
      fips[6]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
      fips[7]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
      fips[8]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f};
      fips[9]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e};
      fips[10] = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
      zk[0] = '{4'd0, 128'h00000000000000000000000000000000};
      zk[1] = '{4'd1, 128'h62636363626363636263636362636363};
      zk[2] = '{4'd2, 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa};
      zk[3] = '{4'd3, 128'h90973450696ccffaf2f457330b0fac99};

      rst_n = 1'b0; start = 1'b0; start_b = 1'b0; key_in = '0; key_b = '0;
`ifdef KEY_EXP_STORE_EN
      rd_idx = 4'd0; rd_idx_b = 4'd0;
`endif
      step();
      step();
      chk("rst_busy",  128'(busy),     128'(0));
      chk("rst_valid", 128'(rk_valid), 128'(0));
      chk("rst_done",  128'(done),     128'(0));
      chk("rst_idx",   128'(rk_idx),   128'(0));
      chk("rst_out",   rk_out,         128'(0));
      rst_n = 1'b1;
      step();

      // start held high with key_in changing every cycle
      start = 1'b1; key_in = fips[0].key;
      push_fips(1'b0, 10, 10);
      step();
      chk("held_latency", 128'(rk_valid), 128'(1));
      for (int k = 1; k <= 11; k++) begin
         key_in = rnd128();
         step();
      end
      chk("held_busy_fall",  128'(busy),     128'(0));
      chk("held_valid_fall", 128'(rk_valid), 128'(0));
      key_in = '0;
      push_zero();
      step();
      chk("held_second_start", 128'(rk_valid), 128'(1));
      start = 1'b0; key_in = rnd128();
      run_valid(1'b0, n);
      chk("held_second_len", 128'(n), 128'(11));
      chk("held_sb_empty", 128'(sb.size()), 128'(0));

      // reset while rk_idx==5
      start = 1'b1; key_in = fips[0].key;
      push_fips(1'b0, 10, 5);
      step();
      start = 1'b0;
      repeat (5) step();
      chk("pre_rst_idx", 128'(rk_idx), 128'(5));
      rst_n = 1'b0;
      step();
      chk("midrst_valid", 128'(rk_valid), 128'(0));
      chk("midrst_busy",  128'(busy),     128'(0));
      chk("midrst_out",   rk_out,         128'(0));
      rst_n = 1'b1;
      step();
      chk("midrst_no_valid", 128'(rk_valid), 128'(0));
      chk("midrst_sb_empty", 128'(sb.size()), 128'(0));
      start = 1'b1; key_in = '0;
      push_zero();
      step();
      start = 1'b0;
      run_valid(1'b0, n);
      chk("zero_len", 128'(n), 128'(11));

      // FIPS-197 vector, 1-cycle start
      step();
      start = 1'b1; key_in = fips[0].key;
      push_fips(1'b0, 10, 10);
      step();
      chk("fips_latency", 128'(rk_valid), 128'(1));
      start = 1'b0; key_in = rnd128();
      run_valid(1'b0, n);
      chk("fips_len", 128'(n), 128'(11));
      chk("fips_busy_end", 128'(busy), 128'(0));
      chk("fips_sb_empty", 128'(sb.size()), 128'(0));

`ifdef KEY_EXP_STORE_EN
      rd_idx = 4'd10; #1;
      chk("store_rd10", rd_key, fips[10].key);
      rd_idx = 4'd0;  #1;
      chk("store_rd0", rd_key, fips[0].key);
      rd_idx = 4'd5;  #1;
      chk("store_rd5", rd_key, fips[5].key);
      rd_idx = 4'd15; #1;
      chk("store_rd15", rd_key, 128'(0));
`endif

      // ROUNDS=2 instance
      start_b = 1'b1; key_b = fips[0].key;
      push_fips(1'b1, 2, 2);
      step();
      chk("r2_latency", 128'(rk_valid_b), 128'(1));
      start_b = 1'b0; key_b = rnd128();
      run_valid(1'b1, n);
      chk("r2_len", 128'(n), 128'(3));
      chk("r2_busy_end", 128'(busy_b), 128'(0));
      chk("r2_sb_empty", 128'(sb_b.size()), 128'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
